// File: rtl/phys_reg_file_int.sv
// Integer physical register file: NUM_PREGS x XLEN data plus a per-register ready scoreboard,
// combinational multi-port reads with same-cycle writeback bypass. Preg 0 is hardwired to zero.
module phys_reg_file_int #(
    parameter int XLEN      = 32,
    parameter int NUM_PREGS = 64,
    parameter int NRD       = 4,
    parameter int NWR       = 2,
    parameter int NALLOC    = 2,
    localparam int PW       = $clog2(NUM_PREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD*PW-1:0]      rd_addr,
    output logic [NRD*XLEN-1:0]    rd_data,
    output logic [NRD-1:0]         rd_rdy,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*PW-1:0]      wr_addr,
    input  logic [NWR*XLEN-1:0]    wr_data,
    input  logic [NALLOC-1:0]      alloc_en,
    input  logic [NALLOC*PW-1:0]   alloc_addr,
    input  logic                   flush
);

    logic [XLEN-1:0]      data_r [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_r;
    logic [NUM_PREGS-1:0] ready_nxt_s;

    logic [PW-1:0]   wa_s [NWR];
    logic [XLEN-1:0] wd_s [NWR];
    logic [PW-1:0]   aa_s [NALLOC];

    for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
        assign wa_s[j] = wr_addr[j*PW +: PW];
        assign wd_s[j] = wr_data[j*XLEN +: XLEN];
    end

    for (genvar k = 0; k < NALLOC; k++) begin : g_alloc_unpack
        assign aa_s[k] = alloc_addr[k*PW +: PW];
    end

    // Ready next-state: later stages override earlier ones, giving flush > alloc > write.
    always_comb begin
        ready_nxt_s = ready_r;
        for (int j = 0; j < NWR; j++) begin
            ready_nxt_s[wa_s[j]] = wr_en[j] ? 1'b1 : ready_nxt_s[wa_s[j]];
        end
        for (int k = 0; k < NALLOC; k++) begin
            ready_nxt_s[aa_s[k]] = alloc_en[k] ? 1'b0 : ready_nxt_s[aa_s[k]];
        end
        if (flush) begin
            ready_nxt_s = {NUM_PREGS{1'b1}};
        end else begin
            ready_nxt_s[0] = 1'b1;
        end
    end

    // Register storage; ascending port order lets the highest-index writer land last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                data_r[p] <= {XLEN{1'b0}};
            end
            ready_r <= {NUM_PREGS{1'b1}};
        end else begin
            ready_r <= ready_nxt_s;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wa_s[j] != {PW{1'b0}})) begin
                    data_r[wa_s[j]] <= wd_s[j];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [PW-1:0]   ra_s;
        logic [XLEN-1:0] rdat_s;
        logic            rrdy_s;

        assign ra_s = rd_addr[i*PW +: PW];

        // Stored value, replaced by any matching writeback (highest port last wins).
        always_comb begin
            rdat_s = data_r[ra_s];
            rrdy_s = ready_r[ra_s];
            for (int j = 0; j < NWR; j++) begin
                rdat_s = (wr_en[j] && (wa_s[j] == ra_s)) ? wd_s[j] : rdat_s;
                rrdy_s = (wr_en[j] && (wa_s[j] == ra_s)) ? 1'b1    : rrdy_s;
            end
        end

        // Reset and preg 0 force zero/ready regardless of pending writes.
        assign rd_data[i*XLEN +: XLEN] = (!rst_n || (ra_s == {PW{1'b0}})) ? {XLEN{1'b0}} : rdat_s;
        assign rd_rdy[i]               = (!rst_n || (ra_s == {PW{1'b0}})) ? 1'b1 : rrdy_s;
    end

endmodule
